// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared widths, bubble word and fetch-state encoding for the CPU core.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;
    localparam int                      PC_WIDTH    = 10;
    localparam int                      INSTR_WIDTH = 32;
    localparam logic [PC_WIDTH-1:0]     RESET_PC    = 10'd0;
    localparam logic [INSTR_WIDTH-1:0]  NOP         = 32'h0;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_t;
endpackage

`default_nettype wire

// File: rtl/mux2x1.sv
// ============================================================================
// Module : mux2x1
// Brief  : Library 2:1 multiplexer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mux2x1 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] i_d0,
    input  logic [WIDTH-1:0] i_d1,
    input  logic             i_sel,
    output logic [WIDTH-1:0] o_y
);
    assign o_y = i_sel ? i_d1 : i_d0;
endmodule

`default_nettype wire

// File: rtl/mux4x1.sv
// ============================================================================
// Module : mux4x1
// Brief  : Library 4:1 multiplexer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mux4x1 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] i_d0,
    input  logic [WIDTH-1:0] i_d1,
    input  logic [WIDTH-1:0] i_d2,
    input  logic [WIDTH-1:0] i_d3,
    input  logic [1:0]       i_sel,
    output logic [WIDTH-1:0] o_y
);
    always_comb begin
        o_y = i_d0;
        case (i_sel)
            2'd0: o_y = i_d0;
            2'd1: o_y = i_d1;
            2'd2: o_y = i_d2;
            2'd3: o_y = i_d3;
            default: o_y = i_d0;
        endcase
    end
endmodule

`default_nettype wire

// File: rtl/next_pc_sel.sv
// ============================================================================
// Module : next_pc_sel
// Brief  : Priority select of the next fetch address (stall > jr > jump > branch > +1).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module next_pc_sel
    import cpu_pkg::*;
#(
    parameter int W = cpu_pkg::PC_WIDTH
) (
    input  logic         i_stall,
    input  logic         i_jr,
    input  logic         i_jump,
    input  logic         i_pcsrc,
    input  logic [W-1:0] i_pc_q,
    input  logic [W-1:0] i_branch_target,
    input  logic [W-1:0] i_jaddress,
    input  logic [W-1:0] i_jr_target,
    output logic [W-1:0] o_pc_plus1,
    output logic [W-1:0] o_pc_next,
    output logic         o_redirect
);
    logic [1:0]   w_flow_sel;
    logic [W-1:0] w_flow_pc;

    // Wraps modulo 2^W by construction of the W-bit sum.
    assign o_pc_plus1 = i_pc_q + {{(W-1){1'b0}}, 1'b1};

    always_comb begin
        w_flow_sel = 2'd0;
        if (i_jr)
            w_flow_sel = 2'd3;
        else if (i_jump)
            w_flow_sel = 2'd2;
        else if (i_pcsrc)
            w_flow_sel = 2'd1;
    end

    mux4x1 #(.WIDTH(W)) u_flow_mux (
        .i_d0  (o_pc_plus1),
        .i_d1  (i_branch_target),
        .i_d2  (i_jaddress),
        .i_d3  (i_jr_target),
        .i_sel (w_flow_sel),
        .o_y   (w_flow_pc)
    );

    mux2x1 #(.WIDTH(W)) u_stall_mux (
        .i_d0  (w_flow_pc),
        .i_d1  (i_pc_q),
        .i_sel (i_stall),
        .o_y   (o_pc_next)
    );

    assign o_redirect = ~i_stall & (i_jr | i_jump | i_pcsrc);
endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module : fetch_stage
// Brief  : Instruction-fetch stage with PC, boot FSM and IF/ID pipeline register.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fetch_stage
    import cpu_pkg::*;
#(
    parameter int                           PC_WIDTH    = cpu_pkg::PC_WIDTH,
    parameter int                           INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
    parameter logic [PC_WIDTH-1:0]          RESET_PC    = cpu_pkg::RESET_PC,
    parameter logic [INSTR_WIDTH-1:0]       NOP         = cpu_pkg::NOP
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic                    PCSrc,
    input  logic [PC_WIDTH-1:0]     branchTarget,
    input  logic                    jump,
    input  logic [PC_WIDTH-1:0]     jaddress,
    input  logic                    jr,
    input  logic [PC_WIDTH-1:0]     jrTarget,
    output logic [PC_WIDTH-1:0]     imem_addr,
    input  logic [INSTR_WIDTH-1:0]  imem_data,
    output logic [INSTR_WIDTH-1:0]  instruction_ID,
    output logic [PC_WIDTH-1:0]     PCPlus1_ID,
    output logic                    valid_ID
);
    fetch_state_t           r_state;
    fetch_state_t           w_state_d;
    logic                   w_boot;
    logic [PC_WIDTH-1:0]    r_pc_q;
    logic [PC_WIDTH-1:0]    w_pc_plus1;
    logic [PC_WIDTH-1:0]    w_pc_run;
    logic [PC_WIDTH-1:0]    w_pc_next;
    logic                   w_redirect;

    next_pc_sel #(.W(PC_WIDTH)) u_next_pc_sel (
        .i_stall         (stall),
        .i_jr            (jr),
        .i_jump          (jump),
        .i_pcsrc         (PCSrc),
        .i_pc_q          (r_pc_q),
        .i_branch_target (branchTarget),
        .i_jaddress      (jaddress),
        .i_jr_target     (jrTarget),
        .o_pc_plus1      (w_pc_plus1),
        .o_pc_next       (w_pc_run),
        .o_redirect      (w_redirect)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= ST_BOOT;
        else
            r_state <= w_state_d;
    end

    always_comb begin
        w_state_d = r_state;
        w_boot    = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_boot    = 1'b1;
                w_state_d = ST_RUN;
            end
            ST_RUN:  w_state_d = ST_RUN;
            default: w_state_d = ST_BOOT;
        endcase
    end

    // BOOT overrides every control input, which also covers the held-in-reset case.
    assign w_pc_next = w_boot ? RESET_PC : w_pc_run;
    assign imem_addr = w_pc_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_pc_q <= RESET_PC;
        else
            r_pc_q <= w_pc_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instruction_ID <= NOP;
            PCPlus1_ID     <= '0;
            valid_ID       <= 1'b0;
        end else if (w_boot || w_redirect) begin
            instruction_ID <= NOP;
            PCPlus1_ID     <= '0;
            valid_ID       <= 1'b0;
        end else if (!stall) begin
            instruction_ID <= imem_data;
            PCPlus1_ID     <= w_pc_plus1;
            valid_ID       <= 1'b1;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module : tb_fetch_stage
// Brief  : Scoreboard bench for fetch_stage with a synchronous-read imem model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        PCSrc = 1'b0;
    logic [9:0]  branchTarget = '0;
    logic        jump = 1'b0;
    logic [9:0]  jaddress = '0;
    logic        jr = 1'b0;
    logic [9:0]  jrTarget = '0;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data = '0;
    logic [31:0] instruction_ID;
    logic [9:0]  PCPlus1_ID;
    logic        valid_ID;

    typedef struct {
        logic [31:0] instr;
        logic [9:0]  pcp1;
        logic        valid;
    } ifid_t;

    ifid_t q_exp[$];
    int    n_checks = 0;
    int    n_errors = 0;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .PCSrc          (PCSrc),
        .branchTarget   (branchTarget),
        .jump           (jump),
        .jaddress       (jaddress),
        .jr             (jr),
        .jrTarget       (jrTarget),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .instruction_ID (instruction_ID),
        .PCPlus1_ID     (PCPlus1_ID),
        .valid_ID       (valid_ID)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [9:0] a);
        return 32'h1000_0000 + {22'd0, a};
    endfunction

    always @(posedge clk) imem_data <= mem(imem_addr);

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_bubble(input string tag);
        check({tag, ".instr"}, 64'(instruction_ID), 64'h0);
        check({tag, ".pcp1"},  64'(PCPlus1_ID),     64'h0);
        check({tag, ".valid"}, 64'(valid_ID),       64'h0);
    endtask

    // One clock: drive controls, check the combinational fetch address, then
    // score the IF/ID contents that the following edge produces.
    task automatic cyc(input logic s, input logic jrv, input logic jv, input logic pv,
                       input logic [9:0] bt, input logic [9:0] ja, input logic [9:0] jt,
                       input logic [9:0] eaddr,
                       input logic [31:0] ei, input logic [9:0] ep, input logic ev);
        ifid_t e;
        @(negedge clk);
        stall = s; jr = jrv; jump = jv; PCSrc = pv;
        branchTarget = bt; jaddress = ja; jrTarget = jt;
        #1;
        check("imem_addr", 64'(imem_addr), 64'(eaddr));
        q_exp.push_back('{instr: ei, pcp1: ep, valid: ev});
        @(posedge clk);
        #1;
        if (q_exp.size() == 0) begin
            check("scoreboard_empty", 64'd0, 64'd1);
        end else begin
            e = q_exp.pop_front();
            check("ifid.instr", 64'(instruction_ID), 64'(e.instr));
            check("ifid.pcp1",  64'(PCPlus1_ID),     64'(e.pcp1));
            check("ifid.valid", 64'(valid_ID),       64'(e.valid));
        end
    endtask

    task automatic run(input logic [9:0] eaddr, input logic [31:0] ei,
                       input logic [9:0] ep, input logic ev);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 10'd0, eaddr, ei, ep, ev);
    endtask

    initial begin
        #12;
        check_bubble("reset");
        check("reset.imem_addr", 64'(imem_addr), 64'h0);
        @(posedge clk);
        #3 rst = 1'b1;

        // Boot bubble, then sequential fetch up to pc_q=5
        run(10'd0, 32'h0, 10'd0, 1'b0);
        run(10'd1, mem(10'd0), 10'd1, 1'b1);
        run(10'd2, mem(10'd1), 10'd2, 1'b1);
        run(10'd3, mem(10'd2), 10'd3, 1'b1);
        run(10'd4, mem(10'd3), 10'd4, 1'b1);
        run(10'd5, mem(10'd4), 10'd5, 1'b1);

        // Stall three cycles at pc_q=5, one of them with a jump that must be ignored
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0,   10'd0, 10'd5, mem(10'd4), 10'd5, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 10'd0, 10'd100, 10'd0, 10'd5, mem(10'd4), 10'd5, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0,   10'd0, 10'd5, mem(10'd4), 10'd5, 1'b1);
        run(10'd6, mem(10'd5), 10'd6, 1'b1);
        run(10'd7, mem(10'd6), 10'd7, 1'b1);

        // Taken branch at pc_q=7 -> 40, single bubble
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 10'd40, 10'd0, 10'd0, 10'd40, 32'h0, 10'd0, 1'b0);
        run(10'd41, mem(10'd40), 10'd41, 1'b1);

        // stall+jump together holds; jump honoured next cycle
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 10'd0, 10'd100, 10'd0, 10'd41,  mem(10'd40), 10'd41, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 10'd100, 10'd0, 10'd100, 32'h0,       10'd0,  1'b0);
        run(10'd101, mem(10'd100), 10'd101, 1'b1);

        // Wrap-around through 1023
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 10'd1022, 10'd0, 10'd1022, 32'h0, 10'd0, 1'b0);
        run(10'd1023, mem(10'd1022), 10'd1023, 1'b1);
        run(10'd0,    mem(10'd1023), 10'd0,    1'b1);
        run(10'd1,    mem(10'd0),    10'd1,    1'b1);

        // jr, jump and PCSrc together: jrTarget wins
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 10'd600, 10'd500, 10'd300, 10'd300, 32'h0, 10'd0, 1'b0);
        run(10'd301, mem(10'd300), 10'd301, 1'b1);
        run(10'd302, mem(10'd301), 10'd302, 1'b1);

        // Asynchronous reset mid-cycle
        #2 rst = 1'b0;
        #1;
        check_bubble("async_rst");
        check("async_rst.imem_addr", 64'(imem_addr), 64'h0);
        @(posedge clk);
        #1;
        check_bubble("rst_held");
        #2 rst = 1'b1;
        run(10'd0, 32'h0,      10'd0, 1'b0);
        run(10'd1, mem(10'd0), 10'd1, 1'b1);
        run(10'd2, mem(10'd1), 10'd2, 1'b1);

        check("scoreboard_drained", 64'(q_exp.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
